proc_controller: RTL and testbench
==================================

PROC_CONTROLLER -- requirements
Module: proc_controller

Interface
REQ-001 Clk  in  1  single system clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 Run  in  1  execution enable; sampled only in FETCH.
REQ-004 IR_in  in  16  instruction word from instruction ROM (registered output, 1-clock read latency).
REQ-005 PC_addr  out  7  instruction ROM address = internal program counter.
REQ-006 D_addr  out  8  data memory address.
REQ-007 D_wr  out  1  data memory write strobe.
REQ-008 RF_s  out  1  register-file write-data select (1 = data memory, 0 = ALU).
REQ-009 RF_W_addr  out  4  register-file write address.
REQ-010 RF_W_en  out  1  register-file write enable.
REQ-011 RF_Ra_addr  out  4  register-file read port A address.
REQ-012 RF_Rb_addr  out  4  register-file read port B address.
REQ-013 ALU_s0  out  3  ALU function select: 000 pass/idle, 001 add, 010 subtract.
REQ-014 State  out  4  current state code, for debug.
REQ-015 Halted  out  1  high while in HALT.

Function
REQ-016 Instruction format: IR[15:12] opcode; opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; opcodes 0110-1111 SHALL execute as NOOP.
REQ-017 States and codes: INIT=0, FETCH=1, FETCH_WAIT=2, DECODE=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9; no other code is reachable.
REQ-018 INIT -> FETCH unconditionally on the next edge.
REQ-019 FETCH: PC_addr = PC; Run=1 -> FETCH_WAIT; Run=0 -> remain in FETCH, PC unchanged.
REQ-020 FETCH_WAIT: at end of cycle, IR <= IR_in and PC <= PC+1, wrapping 127 -> 0; -> DECODE.
REQ-021 DECODE: dispatch on IR[15:12]: LOAD->LOAD_A, STORE->STORE, ADD->ADD, SUB->SUB, HALT->HALT, NOOP/undefined->FETCH.
REQ-022 LOAD (R[IR[3:0]] = M[IR[11:4]]): LOAD_A drives D_addr=IR[11:4], RF_s=1; LOAD_B holds both, adds RF_W_addr=IR[3:0], RF_W_en=1; -> FETCH.
REQ-023 STORE (M[IR[7:0]] = R[IR[11:8]]): D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1 for exactly one cycle; -> FETCH.
REQ-024 ADD/SUB (R[IR[3:0]] = R[IR[11:8]] +/- R[IR[7:4]]): RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, ALU_s0=001/010, RF_W_en=1 for one cycle; -> FETCH.
REQ-025 HALT: Halted=1, no strobes; remains in HALT until Reset asserted; Run ignored.
REQ-026 Outside the states named above, D_wr=0, RF_W_en=0, RF_s=0, ALU_s0=000, D_addr/RF address outputs=0; all outputs decoded from State and IR only (Moore).
REQ-027 Cycle counts per instruction with Run=1: NOOP 3, ADD/SUB/STORE 4, LOAD 5; HALT entered 3 cycles after FETCH.
REQ-028 D_wr and RF_W_en SHALL never be high in the same cycle.

Reset
REQ-029 Reset=0 SHALL immediately, independent of Clk, force State=INIT, PC=0, IR=16'h0000, and all strobes/addresses/Halted to 0.
REQ-030 Reset asserted mid-instruction (any state, incl. HALT) SHALL abort it with no partial write after assertion; first fetch after release is address 0.
REQ-031 After release, INIT lasts exactly one clock before FETCH.

Verification
REQ-032 Reset release, Run=1, ROM[0]=16'h2_05_3 (LOAD R3<-M[0x05]): States 0,1,2,3,4,5,1; LOAD_B shows D_addr=0x05, RF_s=1, RF_W_addr=3, RF_W_en=1.
REQ-033 ROM[1]=16'h3_1_2_4 (ADD R4=R1+R2): ADD state shows Ra=1, Rb=2, W_addr=4, ALU_s0=001, RF_W_en=1 for one cycle; SUB variant 16'h4_1_2_4 shows ALU_s0=010.
REQ-034 ROM[2]=16'h1_7_A0 (STORE M[0xA0]=R7): D_wr=1 one cycle, D_addr=0xA0, RF_Ra_addr=7, RF_W_en=0.
REQ-035 Run=0 held 10 cycles in FETCH: State stays 1, PC_addr constant, no strobes; Run=1 resumes at same address.
REQ-036 128 NOOPs (16'h0000) then wrap: PC_addr 127 -> 0; ROM[0]=16'h5000 -> Halted=1, State=9 stays for 20 cycles with Run toggling.
REQ-037 Reset pulsed low asynchronously (between edges) during LOAD_B and during HALT: outputs go to 0 before the next edge; no RF_W_en pulse afterward; restart fetches address 0.

Source files
------------

// File: rtl/proc_controller.sv
// proc_controller -- multi-cycle control unit for a small 16-bit processor.
//
// Fetches instruction words from a registered-output ROM, decodes them and
// sequences the data memory, register file and ALU control strobes. All
// control outputs are Moore: decoded from the current state and the
// instruction register only.
//
// Ports
//   Clk         in   1   system clock, rising edge active
//   Reset       in   1   asynchronous, active-low reset
//   Run         in   1   execution enable, sampled only in FETCH
//   IR_in       in  16   instruction word from ROM (1-clock read latency)
//   PC_addr     out  7   instruction ROM address (program counter)
//   D_addr      out  8   data memory address
//   D_wr        out  1   data memory write strobe
//   RF_s        out  1   register-file write-data select (1 = memory, 0 = ALU)
//   RF_W_addr   out  4   register-file write address
//   RF_W_en     out  1   register-file write enable
//   RF_Ra_addr  out  4   register-file read port A address
//   RF_Rb_addr  out  4   register-file read port B address
//   ALU_s0      out  3   ALU function: 000 pass, 001 add, 010 subtract
//   State       out  4   current state code (debug)
//   Halted      out  1   high while in HALT
//
// There is no valid/ready handshake on this block: the ROM is read with a
// fixed one-cycle latency and the datapath strobes are single-cycle pulses.

module proc_controller (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IR_in,
  output logic [6:0]  PC_addr,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State,
  output logic        Halted
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_LOAD_A     = 4'd4,
    S_LOAD_B     = 4'd5,
    S_STORE      = 4'd6,
    S_ADD        = 4'd7,
    S_SUB        = 4'd8,
    S_HALT       = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;
  logic [3:0]  w_opcode;

  assign w_opcode = r_ir[15:12];

  // State, program counter and instruction register. The ROM word for the
  // address presented in FETCH is valid during FETCH_WAIT, so IR and the
  // PC increment are both taken at the end of FETCH_WAIT. The 7-bit PC
  // wraps 127 -> 0 naturally.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_INIT;
      r_pc    <= 7'd0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH_WAIT) begin
        r_ir <= IR_in;
        r_pc <= r_pc + 7'd1;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next     = r_state;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;

    case (r_state)
      S_INIT:       w_next = S_FETCH;
      S_FETCH:      w_next = Run ? S_FETCH_WAIT : S_FETCH;
      S_FETCH_WAIT: w_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD:  w_next = S_LOAD_A;
          OP_STORE: w_next = S_STORE;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_HALT:  w_next = S_HALT;
          default:  w_next = S_FETCH;  // NOOP and undefined opcodes
        endcase
      end
      // LOAD_A gives the data memory a cycle to return M[addr] before the
      // register file captures it in LOAD_B.
      S_LOAD_A: begin
        D_addr = r_ir[11:4];
        RF_s   = 1'b1;
        w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr    = r_ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = r_ir[3:0];
        RF_W_en   = 1'b1;
        w_next    = S_FETCH;
      end
      S_STORE: begin
        D_addr     = r_ir[7:0];
        RF_Ra_addr = r_ir[11:8];
        D_wr       = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = r_ir[11:8];
        RF_Rb_addr = r_ir[7:4];
        RF_W_addr  = r_ir[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;           // only Reset leaves HALT
        w_next = S_HALT;
      end
      default:      w_next = S_INIT;
    endcase
  end

  assign PC_addr = r_pc;
  assign State   = r_state;

endmodule

// File: tb/tb_proc_controller.sv
// Testbench for proc_controller: a table of single-instruction vectors,
// randomized whole-program traces against an instruction-level reference
// model, and hand-written asynchronous reset sequences.

module tb_proc_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] IR_in;
  logic [6:0]  PC_addr;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;
  logic        Halted;

  proc_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (Run),
    .IR_in      (IR_in),
    .PC_addr    (PC_addr),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State),
    .Halted     (Halted)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 Clk = ~Clk;

  logic [15:0] rom [128];
  always_ff @(posedge Clk) IR_in <= rom[PC_addr];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // ---------------- observation record ----------------
  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } obs_t;

  typedef struct {
    logic [15:0] ir;
    int          n;
    obs_t        last;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q [$];
  bit   run_q [$];
  int   m_pc;
  int   patch_idx;
  logic [15:0] patch_val;
  logic [15:0] prog [128];

  function automatic obs_t mk(input logic [3:0] st, input logic [6:0] pc,
                              input logic [7:0] d_addr, input logic d_wr,
                              input logic rf_s, input logic [3:0] w_addr,
                              input logic w_en, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [2:0] alu,
                              input logic halted);
    obs_t o;
    o.st = st; o.pc = pc; o.d_addr = d_addr; o.d_wr = d_wr; o.rf_s = rf_s;
    o.w_addr = w_addr; o.w_en = w_en; o.ra = ra; o.rb = rb; o.alu = alu;
    o.halted = halted;
    return o;
  endfunction

  function automatic obs_t idle(input logic [3:0] st, input logic [6:0] pc);
    return mk(st, pc, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = State; o.pc = PC_addr; o.d_addr = D_addr; o.d_wr = D_wr;
    o.rf_s = RF_s; o.w_addr = RF_W_addr; o.w_en = RF_W_en;
    o.ra = RF_Ra_addr; o.rb = RF_Rb_addr; o.alu = ALU_s0; o.halted = Halted;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d pc=%0d da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b h=%b required st=%0d pc=%0d da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b h=%b",
               name, a.st, a.pc, a.d_addr, a.d_wr, a.rf_s, a.w_addr, a.w_en, a.ra, a.rb, a.alu, a.halted,
               e.st, e.pc, e.d_addr, e.d_wr, e.rf_s, e.w_addr, e.w_en, e.ra, e.rb, e.alu, e.halted);
    end
    checks++;
    if (D_wr && RF_W_en) begin
      errors++;
      $display("FAIL %s_excl: got D_wr=1 RF_W_en=1 required not both high", name);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  task automatic push(input obs_t o, input bit r);
    exp_q.push_back(o);
    run_q.push_back(r);
  endtask

  // Expected cycle-by-cycle trace of one instruction, including `stall`
  // FETCH cycles with Run low before it is accepted.
  task automatic gen_instr(input logic [15:0] ir, input int stall, input int halt_cycles);
    logic [6:0] p;
    p = 7'(m_pc);
    for (int s = 0; s < stall; s++) push(idle(4'd1, p), 1'b0);
    push(idle(4'd1, p), 1'b1);
    push(idle(4'd2, p), 1'($urandom_range(0, 1)));
    m_pc = (m_pc + 1) % 128;
    p = 7'(m_pc);
    push(idle(4'd3, p), 1'($urandom_range(0, 1)));
    case (ir[15:12])
      4'd1: push(mk(4'd6, p, ir[7:0], 1'b1, 1'b0, 4'h0, 1'b0, ir[11:8], 4'h0, 3'b000, 1'b0),
                 1'($urandom_range(0, 1)));
      4'd2: begin
        push(mk(4'd4, p, ir[11:4], 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0),
             1'($urandom_range(0, 1)));
        push(mk(4'd5, p, ir[11:4], 1'b0, 1'b1, ir[3:0], 1'b1, 4'h0, 4'h0, 3'b000, 1'b0),
             1'($urandom_range(0, 1)));
      end
      4'd3: push(mk(4'd7, p, 8'h00, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'b001, 1'b0),
                 1'($urandom_range(0, 1)));
      4'd4: push(mk(4'd8, p, 8'h00, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'b010, 1'b0),
                 1'($urandom_range(0, 1)));
      4'd5: for (int h = 0; h < halt_cycles; h++)
              push(mk(4'd9, p, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1),
                   1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  // Apply the expected trace; returns in the middle of its last cycle.
  task automatic run_trace(input string name);
    obs_t e;
    bit   r;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      if (i > 0) begin
        @(posedge Clk);
        @(negedge Clk);
      end
      e = exp_q.pop_front();
      r = run_q.pop_front();
      check_obs(name, e);
      Run = r;
      if (i == patch_idx) rom[0] = patch_val;
      i++;
    end
    patch_idx = -1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    Run   = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_obs("reset_hold", idle(4'd0, 7'd0));
    Reset = 1'b1;
    m_pc  = 0;
  endtask

  // ---------------- vector table ----------------
  vec_t tbl [9];

  task automatic table_test(input int k);
    obs_t prev;
    int   n;
    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
    rom[0] = tbl[k].ir;
    apply_reset();
    Run = 1'b1;
    @(negedge Clk);
    checks++;
    if (State !== 4'd1) begin
      errors++;
      $display("FAIL tbl%0d_init_to_fetch: got state %0d required 1", k, State);
    end
    n = 0;
    prev = sample();
    do begin
      prev = sample();
      @(negedge Clk);
      n++;
    end while (!(State == 4'd1 || State == 4'd9) && n < 20);
    checks++;
    if (n != tbl[k].n) begin
      errors++;
      $display("FAIL tbl%0d_cycles: got %0d required %0d", k, n, tbl[k].n);
    end
    checks++;
    if (prev !== tbl[k].last) begin
      errors++;
      $display("FAIL tbl%0d_last: got %h required %h", k, prev, tbl[k].last);
    end
  endtask

  // Async reset between edges, then hold and verify nothing strobes.
  task automatic async_reset_check(input string name);
    #2;
    Reset = 1'b0;
    #1;
    check_obs({name, "_immediate"}, idle(4'd0, 7'd0));
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check_obs({name, "_held"}, idle(4'd0, 7'd0));
    end
    Reset = 1'b1;
    m_pc  = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] op;
    patch_idx = -1;
    patch_val = 16'h0000;

    tbl[0] = '{16'h2053, 5, mk(4'd5, 7'd1, 8'h05, 1'b0, 1'b1, 4'h3, 1'b1, 4'h0, 4'h0, 3'b000, 1'b0)};
    tbl[1] = '{16'h3124, 4, mk(4'd7, 7'd1, 8'h00, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b001, 1'b0)};
    tbl[2] = '{16'h4124, 4, mk(4'd8, 7'd1, 8'h00, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b010, 1'b0)};
    tbl[3] = '{16'h17A0, 4, mk(4'd6, 7'd1, 8'hA0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h7, 4'h0, 3'b000, 1'b0)};
    tbl[4] = '{16'h0000, 3, idle(4'd3, 7'd1)};
    tbl[5] = '{16'hB3C5, 3, idle(4'd3, 7'd1)};
    tbl[6] = '{16'h5000, 3, idle(4'd3, 7'd1)};
    tbl[7] = '{16'hF0FF, 3, idle(4'd3, 7'd1)};
    tbl[8] = '{16'h3ABC, 4, mk(4'd7, 7'd1, 8'h00, 1'b0, 1'b0, 4'hC, 1'b1, 4'hA, 4'hB, 3'b001, 1'b0)};

    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
    @(negedge Clk);
    check_obs("power_on_reset", idle(4'd0, 7'd0));

    for (int k = 0; k < 9; k++) table_test(k);

    // Whole-program passes: pass 0 is 128 NOOPs, pass 1 random opcodes.
    // Both wrap PC 127 -> 0 and hit a HALT patched into ROM[0].
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 128; a++) begin
        if (pass == 0) prog[a] = 16'h0000;
        else begin
          do op = 4'($urandom_range(0, 15)); while (op == 4'd5);
          prog[a] = {op, 12'($urandom)};
        end
        rom[a] = prog[a];
      end
      apply_reset();
      push(idle(4'd0, 7'd0), 1'b1);
      for (int a = 0; a < 128; a++)
        gen_instr(prog[a], (a == 7) ? 10 : int'($urandom_range(0, 3)), 0);
      gen_instr(16'h5000, 2, 20);
      patch_idx = 20;
      patch_val = 16'h5000;
      run_trace(pass == 0 ? "noop_wrap" : "random_prog");
    end

    // Reset during LOAD_B, then restart from address 0.
    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
    rom[0] = 16'h2053;
    rom[1] = 16'h3124;
    apply_reset();
    push(idle(4'd0, 7'd0), 1'b1);
    gen_instr(16'h2053, 0, 0);
    run_trace("load_pre_reset");
    async_reset_check("reset_in_load_b");
    push(idle(4'd0, 7'd0), 1'b1);
    gen_instr(16'h2053, 1, 0);
    gen_instr(16'h3124, 0, 0);
    run_trace("restart_after_load");

    // Reset during HALT, then restart from address 0 with a new program.
    rom[0] = 16'h5000;
    apply_reset();
    push(idle(4'd0, 7'd0), 1'b1);
    gen_instr(16'h5000, 0, 6);
    run_trace("halt_pre_reset");
    rom[0] = 16'h17A0;
    async_reset_check("reset_in_halt");
    push(idle(4'd0, 7'd0), 1'b1);
    gen_instr(16'h17A0, 0, 0);
    gen_instr(16'h3124, 0, 0);
    run_trace("restart_after_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
